// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the CPU front end.
//   fetch_state_t     - state encoding of the fetch FSM
//   PC_WIDTH          - width of program counter, fetch address and instruction word
//   OPC_HLT           - major opcode (instr[15:12]) of the halt instruction
//   RESET_PC_DEFAULT  - default PC loaded on reset
package cpu_pkg;

  localparam int unsigned PC_WIDTH = 16;

  localparam logic [3:0]          OPC_HLT          = 4'hF;
  localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  // Major opcode field of an instruction word.
  function automatic logic [3:0] opcode_of(input logic [PC_WIDTH-1:0] word);
    return word[PC_WIDTH-1 -: 4];
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// pc_fetch
// Instruction-fetch stage. Owns the architectural PC, fetches the word at
// pc_cur through a request/ready handshake, holds it for the datapath and,
// when the datapath accepts it, retires it and loads next_pc from the branch
// logic. Stops for good (until rst) on the halt opcode or on an odd next_pc.
//
// Ports
//   clk           in   clock, all state changes on the rising edge
//   rst           in   synchronous active-high reset
//   imem_req      out  fetch request, high only in REQ
//   imem_addr     out  fetch address (always pc_cur)
//   imem_ready    in   one-cycle pulse, imem_data valid in the same cycle
//   imem_data     in   fetched instruction word
//   pc_cur        out  current PC, feeds the branch logic
//   next_pc       in   next PC from the branch logic, sampled on retire only
//   instr         out  held instruction word
//   instr_valid   out  instr is valid (HOLD)
//   instr_accept  in   datapath consumes instr this cycle (retire)
//   halted        out  fetch stopped on HLT or fault
//   fault         out  halt was caused by an odd next_pc
//   retire_count  out  retired instruction count, wraps at 2^16
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [3:0]          HALT_OPCODE = OPC_HLT
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [PC_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0] pc_cur,
  input  logic [PC_WIDTH-1:0] next_pc,
  output logic [PC_WIDTH-1:0] instr,
  output logic                instr_valid,
  input  logic                instr_accept,
  output logic                halted,
  output logic                fault,
  output logic [15:0]         retire_count
);

  fetch_state_t        state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [PC_WIDTH-1:0] instr_reg, instr_next;
  logic [15:0]         retire_count_reg, retire_count_next;
  logic                fault_reg, fault_next;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      pc_reg           <= RESET_PC;
      instr_reg        <= '0;
      retire_count_reg <= '0;
      fault_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      instr_reg        <= instr_next;
      retire_count_reg <= retire_count_next;
      fault_reg        <= fault_next;
    end
  end

  // Next-state logic. Handshake inputs only matter in the state that owns
  // them, so a stray imem_ready or instr_accept elsewhere falls through to
  // the hold-everything defaults.
  always_comb begin
    state_next        = state_reg;
    pc_next           = pc_reg;
    instr_next        = instr_reg;
    retire_count_next = retire_count_reg;
    fault_next        = fault_reg;

    unique case (state_reg)
      IDLE: begin
        state_next = REQ;
      end

      REQ: begin
        if (imem_ready) begin
          instr_next = imem_data;
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (instr_accept) begin
          // Every accepted instruction retires, including a HLT or one
          // whose successor turns out to be misaligned.
          retire_count_next = retire_count_reg + 16'd1;
          if (opcode_of(instr_reg) == HALT_OPCODE) begin
            // pc stays on the HLT so software can see where it stopped
            state_next = HALTED;
          end else if (next_pc[0]) begin
            fault_next = 1'b1;
            state_next = HALTED;
          end else begin
            pc_next    = next_pc;
            state_next = REQ;
          end
        end
      end

      HALTED: begin
        state_next = HALTED;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs come from registers or the state decode only.
  assign imem_req     = (state_reg == REQ);
  assign instr_valid  = (state_reg == HOLD);
  assign halted       = (state_reg == HALTED);
  assign imem_addr    = pc_reg;
  assign pc_cur       = pc_reg;
  assign instr        = instr_reg;
  assign fault        = fault_reg;
  assign retire_count = retire_count_reg;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [15:0] pc_cur;
  logic [15:0] next_pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_accept;
  logic        halted;
  logic        fault;
  logic [15:0] retire_count;

  int vectors     = 0;
  int miscompares = 0;

  pc_fetch #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_data    (imem_data),
    .pc_cur       (pc_cur),
    .next_pc      (next_pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_accept (instr_accept),
    .halted       (halted),
    .fault        (fault),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change and outputs are
  // sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  initial begin
    rst          = 1'b1;
    imem_ready   = 1'b0;
    imem_data    = 16'h0000;
    next_pc      = 16'h0000;
    instr_accept = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_req",     {15'd0, imem_req},    16'h0000);
    chk("rst_pc",      pc_cur,               16'h0000);
    chk("rst_instr",   instr,                16'h0000);
    chk("rst_count",   retire_count,         16'h0000);
    chk("rst_valid",   {15'd0, instr_valid}, 16'h0000);
    chk("rst_halted",  {15'd0, halted},      16'h0000);
    chk("rst_fault",   {15'd0, fault},       16'h0000);

    // Zero-wait fetch of 0x1234 at 0x0000, accepted in first HOLD cycle
    rst = 1'b0;
    tick();
    chk("t1_req",   {15'd0, imem_req}, 16'h0001);
    chk("t1_addr",  imem_addr,         16'h0000);
    imem_ready = 1'b1;
    imem_data  = 16'h1234;
    tick();
    imem_ready = 1'b0;
    chk("t1_valid", {15'd0, instr_valid}, 16'h0001);
    chk("t1_instr", instr,                16'h1234);
    chk("t1_noreq", {15'd0, imem_req},    16'h0000);
    next_pc      = 16'h0002;
    instr_accept = 1'b1;
    tick();
    instr_accept = 1'b0;
    chk("t1_pc",    pc_cur,            16'h0002);
    chk("t1_count", retire_count,      16'h0001);
    chk("t1_req2",  {15'd0, imem_req}, 16'h0001);

    // Memory answers on the 4th REQ cycle; HOLD stretched for 5 cycles
    chk("t2_addr0", imem_addr, 16'h0002);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t2_req",  {15'd0, imem_req}, 16'h0001);
      chk("t2_addr", imem_addr,         16'h0002);
    end
    imem_ready = 1'b1;
    imem_data  = 16'h2345;
    next_pc    = 16'h0004;
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", {15'd0, instr_valid}, 16'h0001);
      chk("t2_instr", instr,                16'h2345);
      chk("t2_pc",    pc_cur,               16'h0002);
      if (i < 4) tick();
    end
    instr_accept = 1'b1;
    tick();
    instr_accept = 1'b0;
    chk("t2_pc_after", pc_cur,       16'h0004);
    chk("t2_count",    retire_count, 16'h0002);

    // HLT at 0x0004
    imem_ready = 1'b1;
    imem_data  = 16'hF000;
    tick();
    imem_ready   = 1'b0;
    next_pc      = 16'h0010;
    instr_accept = 1'b1;
    tick();
    instr_accept = 1'b0;
    chk("t3_halted", {15'd0, halted}, 16'h0001);
    chk("t3_fault",  {15'd0, fault},  16'h0000);
    chk("t3_pc",     pc_cur,          16'h0004);
    chk("t3_count",  retire_count,    16'h0003);
    for (int i = 0; i < 20; i++) begin
      imem_ready   = i[0];
      instr_accept = ~i[0];
      imem_data    = 16'h0BAD;
      tick();
      chk("t3_req_idle", {15'd0, imem_req}, 16'h0000);
      chk("t3_stay",     {15'd0, halted},   16'h0001);
    end
    imem_ready   = 1'b0;
    instr_accept = 1'b0;
    chk("t3_pc_end",    pc_cur,       16'h0004);
    chk("t3_instr_end", instr,        16'hF000);
    chk("t3_count_end", retire_count, 16'h0003);

    // Misaligned next_pc -> fault
    rst = 1'b1;
    tick();
    chk("t4_rst_halted", {15'd0, halted}, 16'h0000);
    chk("t4_rst_pc",     pc_cur,          16'h0000);
    rst = 1'b0;
    tick();
    imem_ready = 1'b1;
    imem_data  = 16'h5678;
    tick();
    imem_ready   = 1'b0;
    next_pc      = 16'h0013;
    instr_accept = 1'b1;
    tick();
    instr_accept = 1'b0;
    chk("t4_halted", {15'd0, halted}, 16'h0001);
    chk("t4_fault",  {15'd0, fault},  16'h0001);
    chk("t4_pc",     pc_cur,          16'h0000);
    chk("t4_count",  retire_count,    16'h0001);

    // Reset in the middle of a memory wait, late ready during IDLE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("t5_req_wait", {15'd0, imem_req}, 16'h0001);
    rst = 1'b1;
    tick();
    chk("t5_req_drop", {15'd0, imem_req}, 16'h0000);
    chk("t5_pc",       pc_cur,            16'h0000);
    chk("t5_fault",    {15'd0, fault},    16'h0000);
    rst        = 1'b0;
    imem_ready = 1'b1;
    imem_data  = 16'hABCD;
    tick();
    imem_ready = 1'b0;
    chk("t5_no_capture", instr,             16'h0000);
    chk("t5_restart",    {15'd0, imem_req}, 16'h0001);
    chk("t5_addr",       imem_addr,         16'h0000);
    imem_ready = 1'b1;
    imem_data  = 16'h1111;
    tick();
    imem_ready = 1'b0;
    chk("t5_instr", instr,                16'h1111);
    chk("t5_valid", {15'd0, instr_valid}, 16'h0001);

    // Retire counter wrap: ready and accept held high, one retire per 2 edges
    imem_ready   = 1'b1;
    imem_data    = 16'h1234;
    next_pc      = 16'h0002;
    instr_accept = 1'b1;
    repeat (2 * 65535 - 1) @(posedge clk);
    #1;
    chk("t6_count_max", retire_count, 16'hFFFF);
    tick();
    chk("t6_hold_max", retire_count, 16'hFFFF);
    tick();
    chk("t6_wrap", retire_count, 16'h0000);
    imem_ready   = 1'b0;
    instr_accept = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
